// File: rtl/rd_hazard_ctrl_pkg.sv
// Shared types and constants for the read-after-write hazard controller.
`ifndef BANK_ADDR_BITS
`define BANK_ADDR_BITS 3
`endif
`ifndef ROW_ADDR_BITS
`define ROW_ADDR_BITS 14
`endif
`ifndef COL_ADDR_BITS
`define COL_ADDR_BITS 10
`endif

package rd_hazard_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH = `ROW_ADDR_BITS + `COL_ADDR_BITS + `BANK_ADDR_BITS;
    localparam int unsigned N_ENTRIES  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_STALL = 2'd2,
        ST_ISSUE = 2'd3
    } state_e;

endpackage

// File: rtl/rd_hazard_cmp.sv
// Combinational 8-way address comparator; an entry hits only when its valid bit is set.
module rd_hazard_cmp #(
    parameter int unsigned ADDR_WIDTH = rd_hazard_ctrl_pkg::ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]                                   i_addr,
    input  logic [rd_hazard_ctrl_pkg::N_ENTRIES-1:0][ADDR_WIDTH:0]  i_entries,
    output logic [rd_hazard_ctrl_pkg::N_ENTRIES-1:0]                o_hit_c
);

    import rd_hazard_ctrl_pkg::*;

    always_comb begin
        o_hit_c = '0;
        for (int k = 0; k < int'(N_ENTRIES); k++) begin
            o_hit_c[k] = i_entries[k][ADDR_WIDTH] &&
                         (i_entries[k][ADDR_WIDTH-1:0] == i_addr);
        end
    end

endmodule

// File: rtl/rd_hazard_ctrl.sv
// Holds one read and releases it to the read queue only once no buffered write
// targets the same address; stalls meanwhile and asks for write drain priority.
module rd_hazard_ctrl #(
    parameter int unsigned ADDR_WIDTH = rd_hazard_ctrl_pkg::ADDR_WIDTH,
    parameter int unsigned STALL_MAX  = 1023,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rd_valid,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rd_ready,
    input  logic [ADDR_WIDTH:0]   i_waddr_0,
    input  logic [ADDR_WIDTH:0]   i_waddr_1,
    input  logic [ADDR_WIDTH:0]   i_waddr_2,
    input  logic [ADDR_WIDTH:0]   i_waddr_3,
    input  logic [ADDR_WIDTH:0]   i_waddr_4,
    input  logic [ADDR_WIDTH:0]   i_waddr_5,
    input  logic [ADDR_WIDTH:0]   i_waddr_6,
    input  logic [ADDR_WIDTH:0]   i_waddr_7,
    output logic                  o_cmd_valid,
    output logic [ADDR_WIDTH-1:0] o_cmd_addr,
    input  logic                  i_cmd_ready,
    output logic                  o_wr_drain_req,
    output logic [7:0]            o_hit_vec,
    output logic [CNT_WIDTH-1:0]  o_stall_cnt,
    output logic                  o_stall_timeout
);

    import rd_hazard_ctrl_pkg::*;

    localparam int unsigned EP_WIDTH = $clog2(STALL_MAX + 1);

    state_e                              state_q, state_d;
    logic [ADDR_WIDTH-1:0]               hold_q, hold_d;
    logic [N_ENTRIES-1:0]                hit_vec_q, hit_vec_d;
    logic [CNT_WIDTH-1:0]                stall_cnt_q, stall_cnt_d;
    logic [EP_WIDTH-1:0]                 ep_cnt_q, ep_cnt_d;
    logic                                timeout_q, timeout_d;
    logic                                rd_ready_q, rd_ready_d;
    logic                                cmd_valid_q, cmd_valid_d;
    logic                                drain_q, drain_d;

    logic [N_ENTRIES-1:0][ADDR_WIDTH:0]  entries;
    logic [N_ENTRIES-1:0]                hit_c;
    logic                                any_hit_c;

    assign entries = {i_waddr_7, i_waddr_6, i_waddr_5, i_waddr_4,
                      i_waddr_3, i_waddr_2, i_waddr_1, i_waddr_0};

    rd_hazard_cmp #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cmp (
        .i_addr    (hold_q),
        .i_entries (entries),
        .o_hit_c   (hit_c)
    );

    assign any_hit_c = |hit_c;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hit_vec_d   = hit_vec_q;
        stall_cnt_d = stall_cnt_q;
        ep_cnt_d    = ep_cnt_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_rd_valid) begin
                    hold_d  = i_rd_addr;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (any_hit_c) begin
                    hit_vec_d = hit_c;
                    ep_cnt_d  = '0;
                    state_d   = ST_STALL;
                end else begin
                    hit_vec_d = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_STALL: begin
                if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
                end
                if (ep_cnt_q != EP_WIDTH'(STALL_MAX)) begin
                    ep_cnt_d = ep_cnt_q + EP_WIDTH'(1);
                end
                // Timeout only flags the episode; the read keeps waiting
                if (ep_cnt_q == EP_WIDTH'(STALL_MAX - 1)) begin
                    timeout_d = 1'b1;
                end
                if (any_hit_c) begin
                    hit_vec_d = hit_c;
                end else begin
                    hit_vec_d = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Writes arriving now are younger than this read, so no recompare
                if (i_cmd_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rd_ready_d  = (state_d == ST_IDLE);
        cmd_valid_d = (state_d == ST_ISSUE);
        drain_d     = (state_d == ST_STALL);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hit_vec_q   <= '0;
            stall_cnt_q <= '0;
            ep_cnt_q    <= '0;
            timeout_q   <= 1'b0;
            rd_ready_q  <= 1'b1;
            cmd_valid_q <= 1'b0;
            drain_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hit_vec_q   <= hit_vec_d;
            stall_cnt_q <= stall_cnt_d;
            ep_cnt_q    <= ep_cnt_d;
            timeout_q   <= timeout_d;
            rd_ready_q  <= rd_ready_d;
            cmd_valid_q <= cmd_valid_d;
            drain_q     <= drain_d;
        end
    end

    assign o_rd_ready      = rd_ready_q;
    assign o_cmd_valid     = cmd_valid_q;
    assign o_cmd_addr      = hold_q;
    assign o_wr_drain_req  = drain_q;
    assign o_hit_vec       = hit_vec_q;
    assign o_stall_cnt     = stall_cnt_q;
    assign o_stall_timeout = timeout_q;

endmodule

// File: tb/tb_rd_hazard_ctrl.sv
// Scoreboard bench for rd_hazard_ctrl: a driver pushes expected issues computed from
// per-read hit durations, and a monitor checks every presented command against them.
module tb_rd_hazard_ctrl;

    localparam int unsigned AW   = rd_hazard_ctrl_pkg::ADDR_WIDTH;
    localparam int unsigned SMAX = 8;
    localparam int unsigned CW   = 16;

    typedef struct {
        logic [AW-1:0] addr;
        int            acc;
        int            h;
        logic [7:0]    mask;
        int            cnt;
        bit            tmo;
    } exp_t;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_rd_valid;
    logic [AW-1:0] i_rd_addr;
    logic          o_rd_ready;
    logic [AW:0]   wa [8];
    logic          o_cmd_valid;
    logic [AW-1:0] o_cmd_addr;
    logic          i_cmd_ready;
    logic          o_wr_drain_req;
    logic [7:0]    o_hit_vec;
    logic [CW-1:0] o_stall_cnt;
    logic          o_stall_timeout;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   model_cnt = 0;
    bit   model_tmo = 0;
    int   rdy_mode = 1;

    rd_hazard_ctrl #(
        .ADDR_WIDTH (AW),
        .STALL_MAX  (SMAX),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_rd_valid      (i_rd_valid),
        .i_rd_addr       (i_rd_addr),
        .o_rd_ready      (o_rd_ready),
        .i_waddr_0       (wa[0]),
        .i_waddr_1       (wa[1]),
        .i_waddr_2       (wa[2]),
        .i_waddr_3       (wa[3]),
        .i_waddr_4       (wa[4]),
        .i_waddr_5       (wa[5]),
        .i_waddr_6       (wa[6]),
        .i_waddr_7       (wa[7]),
        .o_cmd_valid     (o_cmd_valid),
        .o_cmd_addr      (o_cmd_addr),
        .i_cmd_ready     (i_cmd_ready),
        .o_wr_drain_req  (o_wr_drain_req),
        .o_hit_vec       (o_hit_vec),
        .o_stall_cnt     (o_stall_cnt),
        .o_stall_timeout (o_stall_timeout)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    endtask

    function automatic logic [AW:0] noise(input logic [AW-1:0] a);
        logic [AW-1:0] d;
        if ($urandom_range(0, 1) == 1) return {1'b0, a};
        d = AW'($urandom);
        if (d == '0) d = AW'(1);
        return {1'b1, a ^ d};
    endfunction

    // Ready source for the read queue: random, always-on, or held off
    initial begin
        i_cmd_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            case (rdy_mode)
                0:       i_cmd_ready = ($urandom_range(0, 3) != 0);
                1:       i_cmd_ready = 1'b1;
                default: i_cmd_ready = 1'b0;
            endcase
        end
    end

    // One read whose hit entries (mask) stay visible for h cycles starting at the check cycle
    task automatic do_read(input logic [AW-1:0] a, input int h, input logic [7:0] m,
                           input logic [7:0] inv_m, input bit tchk);
        exp_t e;
        int   n;
        n = 0;
        while (!o_rd_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_rd_ready) begin
            chk("rd_ready_wait", 32'(o_rd_ready), 32'd1);
            return;
        end
        for (int k = 0; k < 8; k++) begin
            if (m[k])          wa[k] = {1'b1, a};
            else if (inv_m[k]) wa[k] = {1'b0, a};
            else               wa[k] = noise(a);
        end
        i_rd_valid = 1'b1;
        i_rd_addr  = a;
        model_cnt  = (model_cnt + h > 65535) ? 65535 : model_cnt + h;
        if (h >= int'(SMAX)) model_tmo = 1'b1;
        e.addr = a; e.acc = cyc; e.h = h; e.mask = m; e.cnt = model_cnt; e.tmo = model_tmo;
        q.push_back(e);
        for (int k = 1; k <= h + 1; k++) begin
            @(negedge i_clk);
            if (k == 1) begin
                chk("rd_ready_after_accept", 32'(o_rd_ready), 32'd0);
                i_rd_valid = 1'($urandom_range(0, 1));
                i_rd_addr  = AW'($urandom);
            end
            if (tchk && k == int'(SMAX) + 1) chk("timeout_before", 32'(o_stall_timeout), 32'd0);
            if (tchk && k == int'(SMAX) + 2) chk("timeout_rise", 32'(o_stall_timeout), 32'd1);
            if (k == h + 1) begin
                for (int j = 0; j < 8; j++) if (m[j]) wa[j] = noise(a);
            end
        end
        @(negedge i_clk);
        i_rd_valid = 1'b0;
        i_rd_addr  = AW'($urandom);
    endtask

    // Monitor: compares every presented command and every stall cycle against the queue head
    initial begin
        bit seen;
        int dr;
        seen = 1'b0;
        dr   = 0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                seen = 1'b0;
                dr   = 0;
                continue;
            end
            if (o_wr_drain_req) begin
                if (q.size() > 0) chk("hit_vec_stall", 32'(o_hit_vec), 32'(q[0].mask));
                dr++;
            end
            if (o_cmd_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_cmd", 32'(o_cmd_valid), 32'd0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("cmd_addr", 32'(o_cmd_addr), 32'(q[0].addr));
                        chk("issue_latency", 32'(cyc - q[0].acc), 32'(2 + q[0].h));
                        chk("stall_cycles", 32'(dr), 32'(q[0].h));
                        chk("stall_cnt", 32'(o_stall_cnt), 32'(q[0].cnt));
                        chk("stall_timeout", 32'(o_stall_timeout), 32'(q[0].tmo));
                        chk("hit_vec_issue", 32'(o_hit_vec), 32'd0);
                    end else begin
                        chk("cmd_addr_hold", 32'(o_cmd_addr), 32'(q[0].addr));
                        chk("rd_ready_in_issue", 32'(o_rd_ready), 32'd0);
                    end
                    if (i_cmd_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                        dr   = 0;
                    end
                end
            end else if (seen) begin
                chk("cmd_valid_hold", 32'(o_cmd_valid), 32'd1);
                void'(q.pop_front());
                seen = 1'b0;
                dr   = 0;
            end
        end
    end

    initial begin
        logic [AW-1:0] a;
        int            h;
        logic [7:0]    m;
        int            n;

        i_rst_n    = 1'b0;
        i_rd_valid = 1'b0;
        i_rd_addr  = '0;
        for (int k = 0; k < 8; k++) wa[k] = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_rd_ready", 32'(o_rd_ready), 32'd1);
        chk("rst_cmd_valid", 32'(o_cmd_valid), 32'd0);
        chk("rst_cmd_addr", 32'(o_cmd_addr), 32'd0);
        chk("rst_drain", 32'(o_wr_drain_req), 32'd0);
        chk("rst_hit_vec", 32'(o_hit_vec), 32'd0);
        chk("rst_stall_cnt", 32'(o_stall_cnt), 32'd0);
        chk("rst_timeout", 32'(o_stall_timeout), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Directed cases
        rdy_mode = 1;
        do_read(AW'(32'h1234), 0, 8'h00, 8'h00, 1'b0);
        do_read(AW'(32'h1234), 5, 8'h08, 8'h00, 1'b0);
        do_read(AW'(32'h1234), 0, 8'h00, 8'h20, 1'b0);
        rdy_mode = 2;
        do_read(AW'(32'h0abc), 0, 8'h00, 8'h00, 1'b0);
        repeat (4) @(negedge i_clk);
        rdy_mode = 1;
        do_read(AW'(32'h0055), 10, 8'h81, 8'h00, 1'b1);

        // Randomized reads with random backpressure
        rdy_mode = 0;
        for (int t = 0; t < 40; t++) begin
            a = ($urandom_range(0, 3) == 0) ? AW'(32'h1234) : AW'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                h = 0;
                m = 8'h00;
            end else begin
                h = $urandom_range(1, 11);
                m = 8'($urandom_range(1, 255));
            end
            do_read(a, h, m, 8'($urandom), 1'b0);
        end

        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);

        // Reset in the middle of a stall discards the held read
        rdy_mode = 1;
        n = 0;
        while (!o_rd_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        for (int k = 0; k < 8; k++) wa[k] = '0;
        wa[2]      = {1'b1, AW'(32'h0777)};
        i_rd_valid = 1'b1;
        i_rd_addr  = AW'(32'h0777);
        @(negedge i_clk);
        i_rd_valid = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("stall_before_reset", 32'(o_wr_drain_req), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_drain", 32'(o_wr_drain_req), 32'd0);
        chk("mid_rst_hit_vec", 32'(o_hit_vec), 32'd0);
        chk("mid_rst_stall_cnt", 32'(o_stall_cnt), 32'd0);
        chk("mid_rst_timeout", 32'(o_stall_timeout), 32'd0);
        chk("mid_rst_rd_ready", 32'(o_rd_ready), 32'd1);
        wa[2] = '0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            chk("no_cmd_after_reset", 32'(o_cmd_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
